dfd_cla_counter_bank: RTL and testbench

Per-counter state machine and arithmetic for the CLA counter actions, placed directly downstream of the CLA action generator. It consumes the registered `counter_controls` array (increment pulse, clear, auto-increment start/stop) and maintains one up-counter per entry. It returns registered value and target-match status to the CLA node condition logic, and exposes values for MMR readback.

---
 rtl/dfd_cla_pkg.sv | 19 +
 rtl/dfd_cla_counter_slice.sv | 78 +++++++
 rtl/tt_dfd_generic_dff.sv | 17 +
 rtl/dfd_cla_counter_bank.sv | 54 +++++
 tb/tb_dfd_cla_counter_bank.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dfd_cla_pkg.sv
// Shared CLA types: counter action strobes, counter FSM states and default sizes.
package dfd_cla_pkg;

  localparam int CLA_NUMBER_OF_COUNTERS = 4;
  localparam int CLA_COUNTER_WIDTH      = 32;

  typedef struct packed {
    logic increment_pulse;
    logic clear_ctr;
    logic auto_increment;
    logic stop_auto_increment;
  } counter_controls;

  typedef enum logic {
    CTR_IDLE = 1'b0,
    CTR_RUN  = 1'b1
  } cla_ctr_state_e;

endpackage

// File: rtl/dfd_cla_counter_slice.sv
// One CLA counter: IDLE/RUN auto-increment FSM, saturating count, sticky overflow
// and a registered target match aligned with the count.
module dfd_cla_counter_slice
  import dfd_cla_pkg::*;
#(
  parameter int CNT_WIDTH = CLA_COUNTER_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_eap,
  input  counter_controls      actions,
  input  logic                 sw_clear,
  input  logic [CNT_WIDTH-1:0] target,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 match,
  output logic                 overflow,
  output cla_ctr_state_e       state
);

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ALL_ONE = '1;

  logic                 act_inc, act_clr, act_auto, act_stop, do_inc;
  cla_ctr_state_e       state_n;
  logic [CNT_WIDTH-1:0] value_n;
  logic                 overflow_n, match_n;
  logic [0:0]           state_q;

  assign act_inc  = enable_eap & actions.increment_pulse;
  assign act_clr  = enable_eap & actions.clear_ctr;
  assign act_auto = enable_eap & actions.auto_increment;
  assign act_stop = enable_eap & actions.stop_auto_increment;

  // The auto_increment strobe itself counts, so the first increment lands with running=1.
  // A pulse while in RUN merges into the same +1.
  assign do_inc = ~act_stop & (act_inc | act_auto | (enable_eap & (state == CTR_RUN)));

  always_comb begin
    state_n = state;
    if (sw_clear || !enable_eap) state_n = CTR_IDLE;
    else if (act_stop)           state_n = CTR_IDLE;
    else if (act_auto)           state_n = CTR_RUN;
    else if (act_clr)            state_n = CTR_IDLE;
  end

  always_comb begin
    value_n    = value;
    overflow_n = overflow;
    if (sw_clear) begin
      value_n    = '0;
      overflow_n = 1'b0;
    end else if (act_clr) begin
      value_n = '0;
    end else if (do_inc) begin
      if (value == ALL_ONE) overflow_n = 1'b1;
      else                  value_n    = value + ONE;
    end
    match_n = (value_n >= target);
  end

  tt_dfd_generic_dff #(.WIDTH(1)) u_state_ff (
    .clk(clock), .reset_n(reset_n), .d(state_n), .q(state_q)
  );
  assign state = cla_ctr_state_e'(state_q);

  tt_dfd_generic_dff #(.WIDTH(CNT_WIDTH)) u_value_ff (
    .clk(clock), .reset_n(reset_n), .d(value_n), .q(value)
  );

  tt_dfd_generic_dff #(.WIDTH(1)) u_overflow_ff (
    .clk(clock), .reset_n(reset_n), .d(overflow_n), .q(overflow)
  );

  tt_dfd_generic_dff #(.WIDTH(1)) u_match_ff (
    .clk(clock), .reset_n(reset_n), .d(match_n), .q(match)
  );

endmodule

// File: rtl/tt_dfd_generic_dff.sv
// Generic register with asynchronous active-low reset to a parameterised value.
module tt_dfd_generic_dff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= RESET_VALUE;
    else          q <= d;
  end

endmodule

// File: rtl/dfd_cla_counter_bank.sv
// Bank of NUM_CTR independent CLA counters driven by the action generator strobes.
// Optional snapshot bank enabled by DFD_CLA_CTR_SNAPSHOT_EN.
// Handshake: all inputs are single-cycle level strobes sampled every clock; no valid/ready.
module dfd_cla_counter_bank
  import dfd_cla_pkg::*;
#(
  parameter int NUM_CTR   = CLA_NUMBER_OF_COUNTERS,
  parameter int CNT_WIDTH = CLA_COUNTER_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_eap,
  input  counter_controls      counter_actions [NUM_CTR],
  input  logic [NUM_CTR-1:0]   sw_clear,
  input  logic [CNT_WIDTH-1:0] counter_target  [NUM_CTR],
  output logic [CNT_WIDTH-1:0] counter_value   [NUM_CTR],
  output logic [NUM_CTR-1:0]   counter_match,
  output logic [NUM_CTR-1:0]   counter_overflow,
  output logic [NUM_CTR-1:0]   counter_running
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
  ,
  input  logic                 snapshot_req,
  output logic [CNT_WIDTH-1:0] counter_snapshot [NUM_CTR]
`endif
);

  cla_ctr_state_e ctr_state [NUM_CTR];

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    dfd_cla_counter_slice #(.CNT_WIDTH(CNT_WIDTH)) u_slice (
      .clock      (clock),
      .reset_n    (reset_n),
      .enable_eap (enable_eap),
      .actions    (counter_actions[i]),
      .sw_clear   (sw_clear[i]),
      .target     (counter_target[i]),
      .value      (counter_value[i]),
      .match      (counter_match[i]),
      .overflow   (counter_overflow[i]),
      .state      (ctr_state[i])
    );
    assign counter_running[i] = (ctr_state[i] == CTR_RUN);

`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    // Captures the registered value, so a same-cycle clear yields the pre-clear count.
    logic [CNT_WIDTH-1:0] snap_d;
    assign snap_d = snapshot_req ? counter_value[i] : counter_snapshot[i];
    tt_dfd_generic_dff #(.WIDTH(CNT_WIDTH)) u_snap_ff (
      .clk(clock), .reset_n(reset_n), .d(snap_d), .q(counter_snapshot[i])
    );
`endif
  end

endmodule

// File: tb/tb_dfd_cla_counter_bank.sv
// Directed bench for dfd_cla_counter_bank with two 8-bit counters.
module tb_dfd_cla_counter_bank;
  import dfd_cla_pkg::*;

  localparam int N = 2;
  localparam int W = 8;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable_eap = 1'b1;
  counter_controls counter_actions [N];
  logic [N-1:0]    sw_clear = '0;
  logic [W-1:0]    counter_target  [N];
  logic [W-1:0]    counter_value   [N];
  logic [N-1:0]    counter_match, counter_overflow, counter_running;
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
  logic            snapshot_req = 1'b0;
  logic [W-1:0]    counter_snapshot [N];
`endif

  int checks = 0;
  int errors = 0;

  dfd_cla_counter_bank #(.NUM_CTR(N), .CNT_WIDTH(W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable_eap       (enable_eap),
    .counter_actions  (counter_actions),
    .sw_clear         (sw_clear),
    .counter_target   (counter_target),
    .counter_value    (counter_value),
    .counter_match    (counter_match),
    .counter_overflow (counter_overflow),
    .counter_running  (counter_running)
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    ,
    .snapshot_req     (snapshot_req),
    .counter_snapshot (counter_snapshot)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1ns after the rising edge, outputs sampled there too
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_actions();
    for (int i = 0; i < N; i++) counter_actions[i] = '0;
  endtask

  task automatic check_ctr0(input string tag, input logic [W-1:0] v, input logic run,
                            input logic mt, input logic ovf);
    check_val({tag, "_value"},   32'(counter_value[0]),  32'(v));
    check_val({tag, "_running"}, 32'(counter_running[0]), 32'(run));
    check_val({tag, "_match"},   32'(counter_match[0]),  32'(mt));
    check_val({tag, "_ovf"},     32'(counter_overflow[0]), 32'(ovf));
  endtask

  initial begin
    idle_actions();
    counter_target[0] = 8'd3;
    counter_target[1] = 8'd0;
    #12;
    check_ctr0("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check_val("reset_match1", 32'(counter_match[1]), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_ctr0("post_reset", 8'd0, 1'b0, 1'b0, 1'b0);
    check_val("tgt0_match1", 32'(counter_match[1]), 32'd1);

    // three increment pulses, target 3
    counter_actions[0].increment_pulse = 1'b1;
    step(); check_ctr0("inc1", 8'd1, 1'b0, 1'b0, 1'b0);
    step(); check_ctr0("inc2", 8'd2, 1'b0, 1'b0, 1'b0);
    step(); check_ctr0("inc3", 8'd3, 1'b0, 1'b1, 1'b0);
    idle_actions();
    counter_actions[0].clear_ctr = 1'b1;
    step(); check_ctr0("clr", 8'd0, 1'b0, 1'b0, 1'b0);
    idle_actions();

    // auto run N..N+5 with a merged pulse inside RUN
    counter_actions[0].auto_increment = 1'b1;
    step(); check_ctr0("auto_first", 8'd1, 1'b1, 1'b0, 1'b0);
    idle_actions();
    for (int k = 0; k < 4; k++) begin
      counter_actions[0].increment_pulse = (k == 1);
      step();
      check_val("auto_run_value", 32'(counter_value[0]), 32'(k + 2));
    end
    idle_actions();
    check_ctr0("auto_before_stop", 8'd5, 1'b1, 1'b1, 1'b0);
    counter_actions[0].stop_auto_increment = 1'b1;
    step(); check_ctr0("auto_stop", 8'd5, 1'b0, 1'b1, 1'b0);
    idle_actions();

    // clear + pulse + auto in one cycle
    counter_actions[0] = '{increment_pulse: 1'b1, clear_ctr: 1'b1,
                           auto_increment: 1'b1, stop_auto_increment: 1'b0};
    step(); check_ctr0("prio", 8'd0, 1'b1, 1'b0, 1'b0);
    idle_actions();
    step(); check_ctr0("prio_next", 8'd1, 1'b1, 1'b0, 1'b0);
    counter_actions[0].stop_auto_increment = 1'b1;
    step(); check_ctr0("prio_stop", 8'd1, 1'b0, 1'b0, 1'b0);
    idle_actions();

    // disable during RUN
    counter_actions[0].auto_increment = 1'b1;
    step(); check_ctr0("dis_run", 8'd2, 1'b1, 1'b0, 1'b0);
    counter_actions[0] = '{increment_pulse: 1'b1, clear_ctr: 1'b0,
                           auto_increment: 1'b0, stop_auto_increment: 1'b0};
    enable_eap = 1'b0;
    step(); check_ctr0("dis_hold", 8'd2, 1'b0, 1'b0, 1'b0);
    counter_actions[0].clear_ctr = 1'b1;
    step(); check_ctr0("dis_ignore", 8'd2, 1'b0, 1'b0, 1'b0);
    idle_actions();
    sw_clear[0] = 1'b1;
    step(); check_ctr0("dis_swclr", 8'd0, 1'b0, 1'b0, 1'b0);
    sw_clear[0] = 1'b0;
    enable_eap = 1'b1;

    // auto and stop together: stop wins
    counter_actions[0].auto_increment = 1'b1;
    counter_actions[0].stop_auto_increment = 1'b1;
    step(); check_ctr0("auto_stop_same", 8'd0, 1'b0, 1'b0, 1'b0);
    idle_actions();

    // saturation at 0xFF
    counter_target[0] = 8'hFF;
    counter_actions[0].auto_increment = 1'b1;
    step();
    idle_actions();
    repeat (253) step();
    check_ctr0("sat_pre", 8'hFE, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    check_ctr0("sat", 8'hFF, 1'b1, 1'b1, 1'b1);
    counter_actions[0].clear_ctr = 1'b1;
    step(); check_ctr0("sat_clr", 8'd0, 1'b0, 1'b0, 1'b1);
    idle_actions();
    sw_clear[0] = 1'b1;
    step(); check_ctr0("sat_swclr", 8'd0, 1'b0, 1'b0, 1'b0);
    sw_clear[0] = 1'b0;

    // counter 1 untouched by everything above
    check_val("indep_value1", 32'(counter_value[1]), 32'd0);
    check_val("indep_ovf1", 32'(counter_overflow[1]), 32'd0);
    check_val("indep_run1", 32'(counter_running[1]), 32'd0);

    // target change shows on match one edge later
    counter_target[0] = 8'd0;
    #1; check_val("tgt_lag_before", 32'(counter_match[0]), 32'd0);
    step(); check_val("tgt_lag_after", 32'(counter_match[0]), 32'd1);

`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    counter_actions[0].increment_pulse = 1'b1;
    repeat (7) step();
    idle_actions();
    check_val("snap_pre", 32'(counter_value[0]), 32'd7);
    snapshot_req = 1'b1;
    counter_actions[0].clear_ctr = 1'b1;
    step();
    snapshot_req = 1'b0;
    idle_actions();
    check_val("snap_value", 32'(counter_snapshot[0]), 32'd7);
    check_val("snap_clr", 32'(counter_value[0]), 32'd0);
`endif

    // reset mid-RUN
    counter_actions[0].auto_increment = 1'b1;
    step();
    idle_actions();
    step();
    check_ctr0("pre_rst", 8'd2, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check_ctr0("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef DFD_CLA_CTR_SNAPSHOT_EN
    check_val("mid_rst_snap", 32'(counter_snapshot[0]), 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    step(); step();
    check_val("post_rst_value", 32'(counter_value[0]), 32'd0);
    check_val("post_rst_run", 32'(counter_running[0]), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
